// File: rtl/vga_sync_test_01_pkg.sv
// Shared 640x480@60 Hz timing constants, coordinate/colour widths and
// small helpers used by the VGA timing generator and test-pattern top.
package vga_sync_test_01_pkg;

    // Coordinate and colour channel widths
    localparam int COORD_W = 10;
    localparam int COLOR_W = 4;

    // Horizontal timing, in pixel clocks
    localparam int H_VISIBLE_D = 640;
    localparam int H_FRONT_D   = 16;
    localparam int H_SYNC_D    = 96;
    localparam int H_BACK_D    = 48;
    localparam int H_TOTAL_D   = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;

    // Vertical timing, in lines
    localparam int V_VISIBLE_D = 480;
    localparam int V_FRONT_D   = 10;
    localparam int V_SYNC_D    = 2;
    localparam int V_BACK_D    = 33;
    localparam int V_TOTAL_D   = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;

    // One pixel worth of colour
    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
    } rgb_t;

    // True when pos lies in the half-open window [lo, lo+len)
    function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                     input int lo,
                                     input int len);
        return (int'(pos) >= lo) && (int'(pos) < (lo + len));
    endfunction

endpackage

// File: rtl/vga_sync_test_01_timing_counter.sv
// Column/row raster counters with combinational sync and visible decode.
// Decode is taken straight from the registered counters, so hsync, vsync
// and visible line up with column/row in the same cycle.
module vga_timing_counter
    import vga_sync_test_01_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_D,
    parameter int H_FRONT   = H_FRONT_D,
    parameter int H_SYNC    = H_SYNC_D,
    parameter int H_BACK    = H_BACK_D,
    parameter int V_VISIBLE = V_VISIBLE_D,
    parameter int V_FRONT   = V_FRONT_D,
    parameter int V_SYNC    = V_SYNC_D,
    parameter int V_BACK    = V_BACK_D
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] column,
    output logic [COORD_W-1:0] row,
    output logic               visible,
    output logic               hsync,
    output logic               vsync
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Last legal coordinate on each axis; the counters wrap after these
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    // Sync pulses start right after the front porch
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;

    // Raster scan: column every clock, row on column wrap, both wrap at frame end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            column <= '0;
            row    <= '0;
        end else if (column == H_LAST) begin
            column <= '0;
            if (row == V_LAST) begin
                row <= '0;
            end else begin
                row <= row + 1'b1;
            end
        end else begin
            column <= column + 1'b1;
        end
    end

    // Active-low syncs and the visible window, decoded from the current position
    always_comb begin
        hsync   = ~in_span(column, H_SYNC_START, H_SYNC);
        vsync   = ~in_span(row, V_SYNC_START, V_SYNC);
        visible = in_span(column, 0, H_VISIBLE) && in_span(row, 0, V_VISIBLE);
    end

endmodule

// File: rtl/vga_sync_test_01.sv
// 640x480@60 Hz VGA timing generator with a fixed test pattern.
// Inside the visible window red follows column[7:4], green follows
// row[7:4] and blue is their XOR, giving 16-pixel bands and a checker
// of colours; outside the window all channels are driven black.
module vga_sync_test_01
    import vga_sync_test_01_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_D,
    parameter int H_FRONT   = H_FRONT_D,
    parameter int H_SYNC    = H_SYNC_D,
    parameter int H_BACK    = H_BACK_D,
    parameter int V_VISIBLE = V_VISIBLE_D,
    parameter int V_FRONT   = V_FRONT_D,
    parameter int V_SYNC    = V_SYNC_D,
    parameter int V_BACK    = V_BACK_D
) (
    input  logic               clk,
    input  logic               reset,
    output logic               visible,
    output logic               hsync,
    output logic               vsync,
    output logic [COORD_W-1:0] column,
    output logic [COORD_W-1:0] row,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    rgb_t pix;

    vga_timing_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk     (clk),
        .reset   (reset),
        .column  (column),
        .row     (row),
        .visible (visible),
        .hsync   (hsync),
        .vsync   (vsync)
    );

    // Test pattern from the current position; black during blanking
    always_comb begin
        pix = '0;
        if (visible) begin
            pix.red   = column[7:4];
            pix.green = row[7:4];
            pix.blue  = column[7:4] ^ row[7:4];
        end
    end

    assign red   = pix.red;
    assign green = pix.green;
    assign blue  = pix.blue;

endmodule

// File: tb/tb_vga_sync_test_01.sv
// Directed, table-driven bench for vga_sync_test_01. One instance uses the
// full 640x480 timing; a second instance uses a shrunken raster
// (80 x 50: 64+4+8+4 columns, 40+3+2+5 rows) so frame wrap, vsync and a
// multi-frame soak fit in a short run.
module tb_vga_sync_test_01;

    logic       clk;
    logic       reset_f, reset_s;

    logic       vis_f, hs_f, vs_f;
    logic [9:0] col_f, row_f;
    logic [3:0] r_f, g_f, b_f;

    logic       vis_s, hs_s, vs_s;
    logic [9:0] col_s, row_s;
    logic [3:0] r_s, g_s, b_s;

    int n_vec = 0;
    int n_err = 0;
    int pos_f = 0;
    int pos_s = 0;

    vga_sync_test_01 dut (
        .clk(clk), .reset(reset_f), .visible(vis_f), .hsync(hs_f), .vsync(vs_f),
        .column(col_f), .row(row_f), .red(r_f), .green(g_f), .blue(b_f)
    );

    vga_sync_test_01 #(
        .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(40), .V_FRONT(3), .V_SYNC(2), .V_BACK(5)
    ) dut_s (
        .clk(clk), .reset(reset_s), .visible(vis_s), .hsync(hs_s), .vsync(vs_s),
        .column(col_s), .row(row_s), .red(r_s), .green(g_s), .blue(b_s)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        bit sm;
        int c;
        int r;
        int vis;
        int hs;
        int vs;
        int rd;
        int gr;
        int bl;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Check every output of the selected instance against one record
    task automatic chk_all(input string tag, input bit sm, input int c, input int r,
                           input int vis, input int hs, input int vs,
                           input int rd, input int gr, input int bl);
        if (sm) begin
            chk({tag, ".column"}, int'(col_s), c);
            chk({tag, ".row"}, int'(row_s), r);
            chk({tag, ".visible"}, int'(vis_s), vis);
            chk({tag, ".hsync"}, int'(hs_s), hs);
            chk({tag, ".vsync"}, int'(vs_s), vs);
            chk({tag, ".red"}, int'(r_s), rd);
            chk({tag, ".green"}, int'(g_s), gr);
            chk({tag, ".blue"}, int'(b_s), bl);
        end else begin
            chk({tag, ".column"}, int'(col_f), c);
            chk({tag, ".row"}, int'(row_f), r);
            chk({tag, ".visible"}, int'(vis_f), vis);
            chk({tag, ".hsync"}, int'(hs_f), hs);
            chk({tag, ".vsync"}, int'(vs_f), vs);
            chk({tag, ".red"}, int'(r_f), rd);
            chk({tag, ".green"}, int'(g_f), gr);
            chk({tag, ".blue"}, int'(b_f), bl);
        end
    endtask

    // Advance the chosen instance (counted in clocks since its reset release)
    task automatic goto(input bit sm, input int c, input int r);
        int htot;
        int tgt;
        int cur;
        htot = sm ? 80 : 800;
        tgt  = r * htot + c;
        cur  = sm ? pos_s : pos_f;
        if (tgt < cur) begin
            n_vec++;
            n_err++;
            $display("FAIL goto: target index %0d, already at %0d", tgt, cur);
        end else if (tgt > cur) begin
            repeat (tgt - cur) @(posedge clk);
            #1;
        end
        if (sm) pos_s = tgt;
        else    pos_f = tgt;
    endtask

    initial begin
        int hf, vf, vlow, bad;
        bit prev_hs, prev_vs;

        //           sm  col  row vis hs vs  r   g   b
        tbl[0]  = '{0,   0,   0,  1, 1, 1,  0,  0,  0};
        tbl[1]  = '{0,   1,   0,  1, 1, 1,  0,  0,  0};
        tbl[2]  = '{0,  16,   0,  1, 1, 1,  1,  0,  1};
        tbl[3]  = '{0, 639,   0,  1, 1, 1,  7,  0,  7};
        tbl[4]  = '{0, 640,   0,  0, 1, 1,  0,  0,  0};
        tbl[5]  = '{0, 655,   0,  0, 1, 1,  0,  0,  0};
        tbl[6]  = '{0, 656,   0,  0, 0, 1,  0,  0,  0};
        tbl[7]  = '{0, 751,   0,  0, 0, 1,  0,  0,  0};
        tbl[8]  = '{0, 752,   0,  0, 1, 1,  0,  0,  0};
        tbl[9]  = '{0, 799,   0,  0, 1, 1,  0,  0,  0};
        tbl[10] = '{0,   0,   1,  1, 1, 1,  0,  0,  0};
        tbl[11] = '{0, 640,  10,  0, 1, 1,  0,  0,  0};
        tbl[12] = '{0, 100,  37,  1, 1, 1,  6,  2,  4};
        tbl[13] = '{0, 255,  37,  1, 1, 1, 15,  2, 13};
        tbl[14] = '{1,   0,   0,  1, 1, 1,  0,  0,  0};
        tbl[15] = '{1,  63,  39,  1, 1, 1,  3,  2,  1};
        tbl[16] = '{1,  64,  39,  0, 1, 1,  0,  0,  0};
        tbl[17] = '{1,  67,  39,  0, 1, 1,  0,  0,  0};
        tbl[18] = '{1,  68,  39,  0, 0, 1,  0,  0,  0};
        tbl[19] = '{1,  75,  39,  0, 0, 1,  0,  0,  0};
        tbl[20] = '{1,  76,  39,  0, 1, 1,  0,  0,  0};
        tbl[21] = '{1,   5,  40,  0, 1, 1,  0,  0,  0};
        tbl[22] = '{1,  79,  42,  0, 1, 1,  0,  0,  0};
        tbl[23] = '{1,   0,  43,  0, 1, 0,  0,  0,  0};
        tbl[24] = '{1,  79,  44,  0, 1, 0,  0,  0,  0};
        tbl[25] = '{1,   0,  45,  0, 1, 1,  0,  0,  0};
        tbl[26] = '{1,  79,  49,  0, 1, 1,  0,  0,  0};

        reset_f = 1'b1;
        reset_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset_hold", 1'b0, 0, 0, 1, 1, 1, 0, 0, 0);

        // Full-size instance
        @(negedge clk);
        reset_f = 1'b0;
        pos_f   = 0;
        for (int i = 0; i < NV; i++) begin
            if (!tbl[i].sm) begin
                goto(1'b0, tbl[i].c, tbl[i].r);
                chk_all($sformatf("vec%0d", i), 1'b0, tbl[i].c, tbl[i].r, tbl[i].vis,
                        tbl[i].hs, tbl[i].vs, tbl[i].rd, tbl[i].gr, tbl[i].bl);
            end
        end

        // Mid-line asynchronous reset: must clear before any clock edge
        goto(1'b0, 300, 40);
        chk_all("pre_reset", 1'b0, 300, 40, 1, 1, 1, 2, 2, 0);
        #3;
        reset_f = 1'b1;
        #1;
        chk_all("async_reset", 1'b0, 0, 0, 1, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("reset_held_edge", 1'b0, 0, 0, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        reset_f = 1'b0;
        @(posedge clk);
        #1;
        chk_all("first_count", 1'b0, 1, 0, 1, 1, 1, 0, 0, 0);

        // Shrunken instance: vertical timing and frame wrap
        @(negedge clk);
        reset_s = 1'b0;
        pos_s   = 0;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].sm) begin
                goto(1'b1, tbl[i].c, tbl[i].r);
                chk_all($sformatf("vec%0d", i), 1'b1, tbl[i].c, tbl[i].r, tbl[i].vis,
                        tbl[i].hs, tbl[i].vs, tbl[i].rd, tbl[i].gr, tbl[i].bl);
            end
        end
        @(posedge clk);
        #1;
        chk_all("frame_wrap", 1'b1, 0, 0, 1, 1, 1, 0, 0, 0);

        // Soak: 3 x 80 x 60 clocks from a fresh reset release
        reset_s = 1'b1;
        #1;
        @(negedge clk);
        reset_s = 1'b0;
        hf = 0; vf = 0; vlow = 0; bad = 0;
        prev_hs = hs_s;
        prev_vs = vs_s;
        for (int k = 0; k < 14400; k++) begin
            @(posedge clk);
            #1;
            if (col_s > 10'd79 || row_s > 10'd49) bad++;
            if (vis_s && row_s >= 10'd40) bad++;
            if (!vis_s && (r_s != 4'd0 || g_s != 4'd0 || b_s != 4'd0)) bad++;
            if (prev_hs && !hs_s) hf++;
            if (prev_vs && !vs_s) vf++;
            if (!vs_s) vlow++;
            prev_hs = hs_s;
            prev_vs = vs_s;
        end
        chk("soak_range_violations", bad, 0);
        chk("soak_hsync_pulses", hf, 180);
        chk("soak_vsync_pulses", vf, 3);
        chk("soak_vsync_low_clocks", vlow, 480);
        chk("soak_end_column", int'(col_s), 0);
        chk("soak_end_row", int'(row_s), 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
